// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: the 4-bit opcode set and the control FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_NOT = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_MUL = 4'd8,
      OP_ADC = 4'd9,
      OP_SBB = 4'd10
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq
#(
   parameter int WIDTH = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic               busy;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_nxt;

   // The final step's sum is exposed directly so the caller can capture it on the done edge.
   assign prod_nxt = prod + (mplier[0] ? mcand : '0);
   assign done     = busy && (count == LAST);
   assign product  = prod_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         count  <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         prod   <= '0;
      end else if (busy) begin
         prod   <= prod_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            busy <= 1'b0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes; single-cycle ops plus a multi-cycle multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             neg,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic               take;
   logic               load_alu;
   logic               load_mul;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;
   logic               cf;

   logic               cin;
   logic [SHW-1:0]     amt;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic               alu_ovf;
   logic               alu_err;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Shifts use one extra bit so the last bit shifted out lands at a fixed position.
   always_comb begin
      cin       = (op == OP_ADC || op == OP_SBB) ? cf : 1'b0;
      amt       = b[SHW-1:0];
      sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      diff      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      shl_ext   = {1'b0, a} << amt;
      shr_ext   = {a, 1'b0} >> amt;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_err   = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBB: begin
            alu_res   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOT: alu_res = ~a;
         OP_SHL: begin
            alu_res   = shl_ext[WIDTH-1:0];
            alu_carry = shl_ext[WIDTH];
         end
         OP_SHR: begin
            alu_res   = shr_ext[WIDTH:1];
            alu_carry = shr_ext[0];
         end
         OP_MUL: ;
         default: alu_err = 1'b1;
      endcase
   end

   // A beat taken in DONE (output handshake with in_valid) reloads immediately, no bubble.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      load_alu  = 1'b0;
      load_mul  = 1'b0;
      mul_start = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: ;
      endcase
      if (rst) begin
         in_ready = 1'b0;
      end
      take = in_valid && in_ready;
      case (state)
         BUSY: begin
            if (mul_done) begin
               state_nxt = DONE;
               load_mul  = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: ;
      endcase
      if (take) begin
         if (op == OP_MUL) begin
            state_nxt = BUSY;
            mul_start = 1'b1;
         end else begin
            state_nxt = DONE;
            load_alu  = 1'b1;
         end
      end
   end

   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Result and flags only change on entry to DONE, so they hold through any output stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
         zero   <= 1'b0;
         carry  <= 1'b0;
         ovf    <= 1'b0;
         neg    <= 1'b0;
         err    <= 1'b0;
         cf     <= 1'b0;
      end else if (load_alu) begin
         result <= alu_res;
         zero   <= (alu_res == '0);
         carry  <= alu_carry;
         ovf    <= alu_ovf;
         neg    <= alu_res[WIDTH-1];
         err    <= alu_err;
         if (!alu_err) begin
            cf <= alu_carry;
         end
      end else if (load_mul) begin
         result <= mul_product[WIDTH-1:0];
         zero   <= (mul_product[WIDTH-1:0] == '0);
         carry  <= |mul_product[2*WIDTH-1:WIDTH];
         ovf    <= 1'b0;
         neg    <= mul_product[WIDTH-1];
         err    <= 1'b0;
         cf     <= |mul_product[2*WIDTH-1:WIDTH];
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq (WIDTH=8) against a reference model through a scoreboard.
module tb_alu_seq;

   typedef struct packed {
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       v;
      logic       n;
      logic       e;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] op;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       zero;
   logic       carry;
   logic       ovf;
   logic       neg;
   logic       err;

   exp_t sb[$];
   exp_t mon_e;
   int   cf_m;
   int   vectors;
   int   miscompares;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .carry     (carry),
      .ovf       (ovf),
      .neg       (neg),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic on plain integers, independent of the bit-level formulation in the design.
   function automatic exp_t model(input int o, input int x, input int y, input int cin);
      exp_t r;
      int   v;
      int   sx;
      int   sy;
      int   sv;
      int   amt;
      int   ci;
      r   = '0;
      sx  = (x > 127) ? x - 256 : x;
      sy  = (y > 127) ? y - 256 : y;
      amt = y % 8;
      ci  = (o == 9 || o == 10) ? cin : 0;
      case (o)
         0, 9: begin
            v     = x + y + ci;
            sv    = sx + sy + ci;
            r.res = 8'(v % 256);
            r.c   = (v > 255);
            r.v   = (sv > 127) || (sv < -128);
         end
         1, 10: begin
            v     = x - y - ci;
            sv    = sx - sy - ci;
            r.res = 8'((v + 512) % 256);
            r.c   = (v < 0);
            r.v   = (sv > 127) || (sv < -128);
         end
         2: r.res = 8'(x & y);
         3: r.res = 8'(x | y);
         4: r.res = 8'(x ^ y);
         5: r.res = 8'(255 - x);
         6: begin
            r.res = 8'((x << amt) & 255);
            r.c   = (amt == 0) ? 1'b0 : 1'((x >> (8 - amt)) & 1);
         end
         7: begin
            r.res = 8'(x >> amt);
            r.c   = (amt == 0) ? 1'b0 : 1'((x >> (amt - 1)) & 1);
         end
         8: begin
            v     = x * y;
            r.res = 8'(v & 255);
            r.c   = ((v >> 8) != 0);
         end
         default: r.e = 1'b1;
      endcase
      r.z = (r.res == 8'd0);
      r.n = r.res[7];
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic rdy, output int waits);
      exp_t e;
      logic got;
      @(negedge clk);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      out_ready = rdy;
      waits     = 0;
      got       = 1'b0;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (in_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         waits++;
      end
      checkOutput("accept", 32'(got), 32'(1));
      if (got) begin
         @(posedge clk);
         e = model(int'(o), int'(x), int'(y), cf_m);
         sb.push_back(e);
         if (int'(o) <= 10) cf_m = int'(e.c);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic waitOutput(input logic chk_busy, output int lat);
      lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         lat++;
         if (out_valid) break;
         if (chk_busy) checkOutput("busy_in_ready", 32'(in_ready), 32'(0));
      end
   endtask

   // Compare every delivered result against the oldest outstanding expectation.
   always begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'(out_valid), 32'(0));
         end else begin
            mon_e = sb.pop_front();
            checkOutput("result", 32'(result), 32'(mon_e.res));
            checkOutput("zero",   32'(zero),   32'(mon_e.z));
            checkOutput("carry",  32'(carry),  32'(mon_e.c));
            checkOutput("ovf",    32'(ovf),    32'(mon_e.v));
            checkOutput("neg",    32'(neg),    32'(mon_e.n));
            checkOutput("err",    32'(err),    32'(mon_e.e));
         end
      end
   end

   initial begin
      int         w;
      int         lat;
      logic [3:0] r_op;
      logic [3:0] t_op[8];
      logic [7:0] t_a[8];
      logic [7:0] t_b[8];
      vectors     = 0;
      miscompares = 0;
      cf_m        = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      op          = 4'd0;
      a           = 8'd0;
      b           = 8'd0;
      t_op = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd6, 4'd7};
      t_a  = '{8'hF0, 8'hA0, 8'hFF, 8'h3C, 8'h40, 8'h02, 8'h01, 8'h80};
      t_b  = '{8'h3C, 8'h05, 8'hFF, 8'h00, 8'h03, 8'h02, 8'h07, 8'h07};

      repeat (3) @(negedge clk);
      #2;
      checkOutput("rst_in_ready",  32'(in_ready),  32'(0));
      checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
      checkOutput("rst_result",    32'(result),    32'(0));
      checkOutput("rst_flags",     32'({zero, carry, ovf, neg, err}), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      #2;
      checkOutput("ready_after_reset", 32'(in_ready), 32'(1));

      applyStimulus(4'd0, 8'hFF, 8'h01, 1'b1, w);
      waitOutput(1'b0, lat);
      checkOutput("lat_add", 32'(lat), 32'(1));
      applyStimulus(4'd9, 8'h00, 8'h00, 1'b1, w);
      waitOutput(1'b0, lat);
      applyStimulus(4'd1, 8'h80, 8'h01, 1'b1, w);
      waitOutput(1'b0, lat);
      applyStimulus(4'd1, 8'h03, 8'h05, 1'b1, w);
      waitOutput(1'b0, lat);
      applyStimulus(4'd10, 8'h03, 8'h05, 1'b1, w);
      waitOutput(1'b0, lat);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(t_op[i], t_a[i], t_b[i], 1'b1, w);
         waitOutput(1'b0, lat);
      end

      applyStimulus(4'd8, 8'h12, 8'h34, 1'b1, w);
      waitOutput(1'b1, lat);
      checkOutput("lat_mul", 32'(lat), 32'(9));
      applyStimulus(4'd8, 8'hFF, 8'hFF, 1'b1, w);
      waitOutput(1'b1, lat);
      checkOutput("lat_mul2", 32'(lat), 32'(9));
      applyStimulus(4'd8, 8'h0F, 8'h03, 1'b1, w);
      waitOutput(1'b0, lat);

      applyStimulus(4'd6, 8'h81, 8'h01, 1'b1, w);
      waitOutput(1'b0, lat);
      applyStimulus(4'd12, 8'h55, 8'h66, 1'b1, w);
      waitOutput(1'b0, lat);
      checkOutput("lat_invalid", 32'(lat), 32'(1));
      applyStimulus(4'd9, 8'h00, 8'h00, 1'b1, w);
      waitOutput(1'b0, lat);
      applyStimulus(4'd7, 8'h81, 8'h00, 1'b1, w);
      waitOutput(1'b0, lat);

      applyStimulus(4'd4, 8'h5A, 8'h0F, 1'b0, w);
      waitOutput(1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         checkOutput("hold_out_valid", 32'(out_valid), 32'(1));
         checkOutput("hold_result",    32'(result),    32'(sb[0].res));
         checkOutput("hold_in_ready",  32'(in_ready),  32'(0));
      end
      applyStimulus(4'd3, 8'h30, 8'h03, 1'b1, w);
      checkOutput("b2b_waits", 32'(w), 32'(0));
      waitOutput(1'b0, lat);
      checkOutput("b2b_lat", 32'(lat), 32'(1));

      applyStimulus(4'd0, 8'hFF, 8'h02, 1'b1, w);
      waitOutput(1'b0, lat);
      applyStimulus(4'd8, 8'h12, 8'h34, 1'b1, w);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      cf_m = 0;
      #1;
      checkOutput("rst_mid_in_ready", 32'(in_ready), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      #2;
      checkOutput("abort_in_ready",  32'(in_ready),  32'(1));
      checkOutput("abort_result",    32'(result),    32'(0));
      checkOutput("abort_flags",     32'({zero, carry, ovf, neg, err}), 32'(0));
      for (int i = 0; i < 10; i++) begin
         checkOutput("abort_out_valid", 32'(out_valid), 32'(0));
         @(negedge clk);
         #2;
      end
      applyStimulus(4'd9, 8'h00, 8'h00, 1'b1, w);
      waitOutput(1'b0, lat);
      applyStimulus(4'd0, 8'h10, 8'h20, 1'b1, w);
      waitOutput(1'b0, lat);
      checkOutput("lat_add_after_abort", 32'(lat), 32'(1));

      for (int i = 0; i < 24; i++) begin
         r_op = 4'($urandom_range(0, 15));
         applyStimulus(r_op, 8'($urandom), 8'($urandom), 1'b1, w);
         waitOutput(1'b0, lat);
         checkOutput("lat_random", 32'(lat), (r_op == 4'd8) ? 32'(9) : 32'(1));
      end

      repeat (2) @(negedge clk);
      #3;
      checkOutput("sb_drained", 32'(sb.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width; legal range is 4..32.
REQ-002 The block SHALL have localparam SHW, equal to $clog2(WIDTH), meaning the shift-amount width.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  the operand/op beat is valid.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 a, b  input  WIDTH each  the operands.
REQ-008 op  input  4  the opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 MUL, 9 ADC, 10 SBB, 11-15 invalid.
REQ-009 out_valid  output  1  the result and flags are valid.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 result  output  WIDTH  the registered result.
REQ-012 zero, carry, ovf, neg, err  output  1 each  the registered flags.

Function
REQ-013 The block SHALL accept a beat only on in_valid && in_ready, and SHALL deliver a result only on out_valid && out_ready.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE, with one operation in flight at a time.
REQ-015 in_ready SHALL be 1 in IDLE, 0 in BUSY, and equal to out_ready in DONE.
REQ-016 On acceptance of a non-MUL op, the block SHALL go to DONE, with result and flags valid on the next cycle (latency 1).
REQ-017 On acceptance of MUL, the block SHALL go to BUSY for exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-018 In DONE, result and flags SHALL hold stable until the output handshake.
REQ-019 On the output handshake, the block SHALL go to IDLE, or SHALL load the new op in the same cycle if in_valid (back-to-back, no bubble).
REQ-020 ADD/ADC SHALL compute a+b(+cf) modulo 2^WIDTH, with carry = bit WIDTH of the sum.
REQ-021 SUB/SBB SHALL compute a-b(-cf) modulo 2^WIDTH, with carry = 1 when a borrow occurs (unsigned a < b+cf).
REQ-022 For ADD/SUB/ADC/SBB, ovf SHALL be the signed two's-complement overflow; for all other ops, ovf SHALL be 0.
REQ-023 AND/OR/XOR/NOT SHALL be bitwise; NOT uses a only; carry SHALL be 0.
REQ-024 SHL/SHR SHALL shift a logically by b[SHW-1:0].
REQ-025 For SHL/SHR, carry SHALL be the last bit shifted out, and 0 when the shift amount is 0.
REQ-026 MUL SHALL compute shift-add unsigned a*b, with result = low WIDTH bits and carry = (high WIDTH bits != 0).
REQ-027 zero SHALL equal (result == 0), and neg SHALL equal result[WIDTH-1], for every op.
REQ-028 cf SHALL be an internal carry register, updated with carry on every entry to DONE, and SHALL be read by ADC/SBB at acceptance.
REQ-029 An invalid op SHALL give result 0, err 1, carry 0, ovf 0, zero 1, latency 1, and leave cf unchanged.
REQ-030 For all valid ops, err SHALL be 0.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL set state=IDLE, out_valid=0, result=0, zero=0, carry=0, ovf=0, neg=0, err=0 and cf=0.
REQ-032 While rst is high, in_ready SHALL be 0.
REQ-033 Reset asserted mid-MUL (BUSY) or in DONE SHALL abort the operation and drop the pending result; no out_valid SHALL follow.

Structure
REQ-034 Package alu_pkg SHALL hold the op enum (4-bit) and the state enum.
REQ-035 Sub-module alu_mul_seq SHALL hold the shift-add multiplier: a start/done handshake, a WIDTH-step counter, and a 2*WIDTH product register.
REQ-036 All other arithmetic SHALL be combinational inside alu_seq, registered at the DONE entry.

Verification (WIDTH=8)
REQ-037 ADD a=0xFF, b=0x01 -> after 1 cycle: result 0x00, zero 1, carry 1, ovf 0; then ADC a=0, b=0 -> result 0x01.
REQ-038 SUB a=0x80, b=0x01 -> result 0x7F, ovf 1, carry 0, neg 0; SUB a=3, b=5 -> result 0xFE, carry 1, neg 1.
REQ-039 MUL a=0x12, b=0x34 -> out_valid exactly 9 cycles after acceptance, in_ready 0 in between, result 0xA8, carry 1 (product 0x03A8).
REQ-040 SHL a=0x81, b=1 -> result 0x02, carry 1; SHR a=0x81, b=0 -> result 0x81, carry 0; op=12 -> err 1, result 0.
REQ-041 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted in the same cycle, next result on the following cycle.
REQ-042 Assert rst for 1 cycle at the 4th BUSY cycle of a MUL -> out_valid stays 0; in_ready=1 on the cycle after reset release; a following ADD completes normally with cf=0.
